// File: rtl/dc_token_ring_rx.sv
// Reader end of a token-ring dual-clock channel: synchronises the writer's toggle tokens
// into clk_i and streams buffer slots out in order on a valid/ready interface.
module dc_token_ring_rx #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [BUFFER_WIDTH-1:0]            writetoken_i,
  input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
  output logic [BUFFER_WIDTH-1:0]            readpointer_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o
);

  localparam int IDX_W = $clog2(BUFFER_WIDTH);

  logic [SYNC_STAGES-1:0][BUFFER_WIDTH-1:0] sync_q;
  logic [BUFFER_WIDTH-1:0]                  wt_sync;

  logic [BUFFER_WIDTH-1:0] readpointer_q, readpointer_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    avail;
  logic                    load;
  logic [DATA_WIDTH-1:0]   slot_data;
  logic [BUFFER_WIDTH-1:0] slot_mask;

  // Token synchroniser: the only logic that ever sees writetoken_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= writetoken_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign wt_sync = sync_q[SYNC_STAGES-1];

  // Slot data needs no synchroniser: the writer leaves a slot untouched while it is pending.
  always_comb begin
    slot_data = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      if (rd_idx_q == IDX_W'(i)) begin
        slot_data = data_async_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    avail         = wt_sync[rd_idx_q] != readpointer_q[rd_idx_q];
    load          = avail && (!valid_q || ready_i);
    slot_mask     = BUFFER_WIDTH'(1) << rd_idx_q;
    readpointer_d = readpointer_q;
    rd_idx_d      = rd_idx_q;
    valid_d       = valid_q;
    data_d        = data_q;
    if (load) begin
      data_d        = slot_data;
      valid_d       = 1'b1;
      readpointer_d = readpointer_q ^ slot_mask;
      if (rd_idx_q == IDX_W'(BUFFER_WIDTH-1)) begin
        rd_idx_d = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      readpointer_q <= '0;
      rd_idx_q      <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
    end else begin
      readpointer_q <= readpointer_d;
      rd_idx_q      <= rd_idx_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
    end
  end

  // Pointer leaves straight from flops so the writer's synchroniser sees single-bit changes.
  assign readpointer_o = readpointer_q;
  assign valid_o       = valid_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_dc_token_ring_rx.sv
// Scoreboard bench for dc_token_ring_rx: a writer model pushes expected words into a queue,
// a monitor pops and compares every accepted output word.
module tb_dc_token_ring_rx;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int SS = 2;

  logic              clk;
  logic              rstn;
  logic [BW-1:0]     writetoken;
  logic [BW*DW-1:0]  data_async;
  logic [BW-1:0]     readpointer;
  logic              valid;
  logic              ready;
  logic [DW-1:0]     data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] sb[$];
  logic [BW-1:0] wt;
  int            wr;
  bit            wr_done;

  dc_token_ring_rx #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .SYNC_STAGES(SS)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .writetoken_i  (writetoken),
    .data_async_i  (data_async),
    .readpointer_o (readpointer),
    .valid_o       (valid),
    .ready_i       (ready),
    .data_o        (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writer: may reuse slot wr only once the reader has handed it back (token == pointer bit).
  task automatic write_word(input logic [DW-1:0] d);
    int budget;
    budget = 200;
    while (wt[wr] != readpointer[wr] && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL writer_slot_timeout: slot %0d never freed", wr);
    end else begin
      data_async[wr*DW +: DW] = d;
      wt[wr] = ~wt[wr];
      writetoken = wt;
      sb.push_back(d);
      wr = (wr == BW-1) ? 0 : wr + 1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    wt = '0;
    writetoken = '0;
    wr = 0;
    sb.delete();
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  // Monitor: every handshake must deliver the oldest outstanding written word.
  always @(negedge clk) begin
    if (rstn && valid && ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h with no word outstanding", data);
      end else begin
        chk("sb_data", data, sb.pop_front());
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rstn)
                   $countones(readpointer ^ $past(readpointer)) <= 1)
    else begin n_fail++; $display("FAIL sva_hamming: pointer %0h", readpointer); end

  assert property (@(posedge clk) disable iff (!rstn)
                   (valid && !ready) |=> (valid && $stable(data)))
    else begin n_fail++; $display("FAIL sva_stall_stable: data %0h", data); end

  initial begin
    int budget;
    logic [DW-1:0] a, b;
    rstn = 1'b0;
    ready = 1'b0;
    wt = '0;
    writetoken = '0;
    data_async = '0;
    wr = 0;
    wr_done = 1'b0;
    #2;
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_rptr", readpointer, 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Single word latency: token change, then three edges until valid.
    ready = 1'b1;
    write_word(32'hCAFE0001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_not_early", valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", valid, 1);
    chk("lat_data", data, 32'hCAFE0001);
    chk("lat_rptr", readpointer, 8'h01);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid_drop", valid, 0);

    // Full buffer behind a stall, then drain at one word per cycle.
    tick();
    ready = 1'b0;
    do_reset();
    for (int k = 0; k < BW; k++) begin
      write_word(DW'(32'h10 + k));
      tick();
    end
    repeat (6) tick();
    @(negedge clk);
    chk("stall_data", data, 32'h10);
    chk("stall_valid", valid, 1);
    chk("stall_rptr", readpointer, 8'h01);
    tick();
    ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k < BW; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("drain_valid", valid, 1);
      chk("drain_data", data, DW'(32'h10 + k));
    end
    @(posedge clk);
    @(negedge clk);
    chk("drain_done", valid, 0);
    chk("drain_rptr", readpointer, 8'hFF);

    // Random stream of 20 words with random backpressure.
    tick();
    wr_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          write_word($urandom);
          repeat ($urandom_range(0, 2)) tick();
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    ready = 1'b1;
    budget = 200;
    while ((sb.size() != 0 || valid) && budget > 0) begin
      tick();
      budget--;
    end
    chk("rand_drain_timeout", budget == 0, 0);
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_rptr_eq_wt", readpointer, wt);

    // Back-to-back: second token already synced when the first word is accepted.
    a = $urandom;
    b = $urandom;
    write_word(a);
    tick();
    write_word(b);
    budget = 20;
    @(negedge clk);
    while (!valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("b2b_timeout", budget == 0, 0);
    chk("b2b_first", data, a);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid_held", valid, 1);
    chk("b2b_second", data, b);

    // Reset with three words pending and a stalled output.
    tick();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      write_word(DW'(32'hA0 + k));
      tick();
    end
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_data", data, 0);
    chk("midrst_rptr", readpointer, 8'h00);
    wt = '0;
    writetoken = '0;
    wr = 0;
    sb.delete();
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    ready = 1'b1;
    write_word(32'h5EED0000);
    budget = 20;
    @(negedge clk);
    while (!valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("post_rst_timeout", budget == 0, 0);
    chk("post_rst_data", data, 32'h5EED0000);
    chk("post_rst_rptr", readpointer, 8'h01);
    repeat (4) tick();
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
